// File: rtl/ssd_pkg.sv
// Shared types and seven-segment patterns ({g,f,e,d,c,b,a}, active-high)
// for the two-digit BCD display driver.
package ssd_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam bcd_t BCD_MAX = 4'd9;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_ssd_driver_if.sv
// Display-side signal bundle: ones digit in, segment/select/status out.
interface bcd_ssd_driver_if;
    import ssd_pkg::*;

    bcd_t bcd_in;
    seg_t seg;
    logic sel;
    bcd_t tens;
    logic roll;
    logic err;

    modport master (output bcd_in, input seg, input sel, input tens, input roll, input err);
    modport slave  (input bcd_in, output seg, output sel, output tens, output roll, output err);

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import ssd_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_ssd_driver.sv
// Two-digit multiplexed seven-segment driver: follows the ones digit from the
// decade counter, derives a tens digit from 9->0 roll-overs, flags bad codes.
module bcd_ssd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
)
(
    input  logic              clk,
    input  logic              rst_n,
    bcd_ssd_driver_if.slave   bus
);

    localparam int             CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    bcd_t             ones_p0;
    bcd_t             prev_p1;
    logic [CNT_W-1:0] cnt;
    logic             sel_q;
    bcd_t             tens_q;
    logic             roll_q;
    logic             err_q;
    seg_t             seg_q;

    logic             wrap;
    logic             sel_nxt;
    logic             blank;
    bcd_t             digit;
    seg_t             digit_seg;

    assign wrap    = (prev_p1 == BCD_MAX) && (ones_p0 == 4'd0);

    // Mux on the next select value so seg and sel change on the same edge.
    assign sel_nxt = sel_q ^ (cnt == CNT_MAX);
    assign digit   = sel_nxt ? tens_q : ones_p0;
    assign blank   = sel_nxt && BLANK_LZ && (tens_q == 4'd0);

    bcd_to_seg u_dec (
        .bcd (digit),
        .seg (digit_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_p0 <= 4'd0;
            prev_p1 <= 4'd0;
            cnt     <= '0;
            sel_q   <= 1'b0;
            tens_q  <= 4'd0;
            roll_q  <= 1'b0;
            err_q   <= 1'b0;
            seg_q   <= SEG_BLANK;
        end else begin
            ones_p0 <= bus.bcd_in;
            prev_p1 <= ones_p0;
            cnt     <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
            sel_q   <= sel_nxt;
            seg_q   <= blank ? SEG_BLANK : digit_seg;
            roll_q  <= 1'b0;
            if (wrap) begin
                if (tens_q == BCD_MAX) begin
                    tens_q <= 4'd0;
                    roll_q <= 1'b1;
                end else begin
                    tens_q <= tens_q + 4'd1;
                end
            end
            err_q   <= err_q | (ones_p0 > BCD_MAX);
        end
    end

    assign bus.seg  = seg_q;
    assign bus.sel  = sel_q;
    assign bus.tens = tens_q;
    assign bus.roll = roll_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_ssd_driver.sv
// Directed bench for bcd_ssd_driver with REFRESH_DIV = 4 and leading-zero blanking.
module tb_bcd_ssd_driver;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   rolls;
    int   doubles;
    logic prev_roll;

    bcd_ssd_driver_if bus ();

    bcd_ssd_driver #(
        .REFRESH_DIV (4),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sel(input logic v);
        int n;
        n = 0;
        while (bus.sel !== v && n < 20) begin
            tick();
            n++;
        end
        chk("wait_sel", {31'd0, bus.sel}, {31'd0, v});
    endtask

    task automatic observe();
        if (bus.roll === 1'b1) begin
            rolls++;
            chk("roll_tens", {28'd0, bus.tens}, 32'd0);
            if (prev_roll === 1'b1) doubles++;
        end
        prev_roll = bus.roll;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; rolls = 0; doubles = 0; prev_roll = 1'b0;
        rst_n = 1'b0;
        bus.bcd_in = 4'd7;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick(); tick(); tick();

        // Asynchronous reset in the middle of a refresh phase
        #3 rst_n = 1'b0;
        #1;
        chk("rst_seg",  {25'd0, bus.seg},  32'h00);
        chk("rst_sel",  {31'd0, bus.sel},  32'd0);
        chk("rst_tens", {28'd0, bus.tens}, 32'd0);
        chk("rst_err",  {31'd0, bus.err},  32'd0);
        chk("rst_roll", {31'd0, bus.roll}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); chk("sel_t1", {31'd0, bus.sel}, 32'd0);
        tick(); chk("sel_t2", {31'd0, bus.sel}, 32'd0);
        tick(); chk("sel_t3", {31'd0, bus.sel}, 32'd0);
        tick(); chk("sel_t4", {31'd0, bus.sel}, 32'd1);

        // Digit display with leading-zero blanking
        wait_sel(1'b0);
        chk("ones_7", {25'd0, bus.seg}, 32'h07);
        wait_sel(1'b1);
        chk("tens_blank", {25'd0, bus.seg}, 32'h00);

        // Single 9 -> 0 wrap, then held 0
        bus.bcd_in = 4'd9;
        tick(); tick(); tick();
        chk("pre_wrap", {28'd0, bus.tens}, 32'd0);
        bus.bcd_in = 4'd0;
        tick(); chk("wrap_e1", {28'd0, bus.tens}, 32'd0);
        tick(); chk("wrap_e2", {28'd0, bus.tens}, 32'd1);
        chk("wrap_roll", {31'd0, bus.roll}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("wrap_once", {28'd0, bus.tens}, 32'd1);
        wait_sel(1'b1);
        chk("tens_1_seg", {25'd0, bus.seg}, 32'h06);
        wait_sel(1'b0);
        chk("ones_0_seg", {25'd0, bus.seg}, 32'h3F);

        // 100 decade sequences plus a closing 0: 100 wraps from tens = 1
        for (int s = 0; s < 100; s++) begin
            for (int d = 0; d < 10; d++) begin
                bus.bcd_in = 4'(d);
                tick();
                observe();
            end
        end
        bus.bcd_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            observe();
        end
        chk("roll_count",  rolls,   32'd10);
        chk("roll_width",  doubles, 32'd0);
        chk("roll_final",  {28'd0, bus.tens}, 32'd1);

        // Illegal code
        bus.bcd_in = 4'd12;
        tick(); chk("err_e1", {31'd0, bus.err}, 32'd0);
        tick(); chk("err_e2", {31'd0, bus.err}, 32'd1);
        wait_sel(1'b0);
        chk("dash_seg", {25'd0, bus.seg}, 32'h40);
        chk("ill_tens", {28'd0, bus.tens}, 32'd1);
        bus.bcd_in = 4'd9;  tick(); tick();
        bus.bcd_in = 4'd12; tick();
        bus.bcd_in = 4'd0;  tick(); tick(); tick();
        chk("ill_nowrap", {28'd0, bus.tens}, 32'd1);
        chk("err_sticky", {31'd0, bus.err},  32'd1);

        // 3 -> 0 and held 0 must not advance tens
        bus.bcd_in = 4'd3; tick(); tick();
        bus.bcd_in = 4'd0;
        for (int i = 0; i < 6; i++) tick();
        chk("nowrap_30", {28'd0, bus.tens}, 32'd1);

        // Reset clears sticky error and tens
        rst_n = 1'b0;
        #1;
        chk("rst2_err",  {31'd0, bus.err},  32'd0);
        chk("rst2_tens", {28'd0, bus.tens}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_ssd_driver.md
# bcd_ssd_driver

Two-digit seven-segment display driver that consumes the 4-bit BCD output of the 1 Hz decade counter and drives a two-digit multiplexed display module (shared segment lines, one digit-select line). It tracks decade roll-overs of the incoming ones digit to maintain its own tens digit, giving a 00–99 display. It also flags illegal BCD codes. It sits directly downstream of the decade counter, on the same clock.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit phase (1 ms at 100 MHz); must be ≥ 2.
- BLANK_LZ, 1: when 1, the tens digit is blanked while tens == 0.
- clk  in  1  system clock (100 MHz on board).
- rst_n  in  1  asynchronous, active-low reset; one clock; no other reset source.
- bcd_in  in  4  ones digit from the decade counter; bit0 = LSB (counter output A), bit3 = MSB (counter output D).
- seg  out  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- sel  out  1  digit select, registered: 0 = ones digit shown, 1 = tens digit shown.
- tens  out  4  current tens digit, BCD 0–9.
- roll  out  1  one-cycle pulse when tens wraps 9→0 (99→00).
- err  out  1  sticky flag, set when an illegal ones code (10–15) is sampled.

## Operation
- Sampling:
  - ones_q <= bcd_in every cycle.
  - prev_q <= ones_q every cycle.
  - bcd_in is synchronous to clk; no synchroniser.
- Wrap detect: wrap = (prev_q == 9) && (ones_q == 0).
  - Only the exact 9→0 transition counts.
  - 9→illegal and illegal→0 do not count.
  - A value held at 0 for many cycles counts once.
- Tens counter, updated on the cycle after wrap is true:
  - tens 0–8 → tens+1.
  - tens 9 → 0, with roll = 1 for that one cycle.
  - roll is registered and high only in the cycle in which tens returns to 0.
- Illegal code: when ones_q ≥ 10:
  - The ones digit displays dash (0x40).
  - err sets on the next edge and stays set until reset.
  - tens is unaffected.
- Refresh:
  - A counter runs 0..REFRESH_DIV-1 and wraps.
  - sel toggles on the edge where the counter equals REFRESH_DIV-1.
- Segment select, seg <= decode(sel ? tens : ones_q):
  - When sel = 1, BLANK_LZ = 1 and tens == 0 → seg = 0x00.
- Decode:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66.
  - 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F.
  - 10–15 = 0x40 (dash).

## Timing
- Reset values (asynchronous, on rst_n low):
  - seg = 0x00, sel = 0, tens = 0, roll = 0, err = 0.
  - ones_q = 0, prev_q = 0, refresh counter = 0.
- Reset deasserted mid-operation: everything restarts from the reset state.
  - The first refresh phase is a full REFRESH_DIV cycles with sel = 0.
- bcd_in → seg latency: 2 edges (ones_q, then seg), when sel = 0 at the second edge.
- Wrap → tens latency:
  - bcd_in goes 9→0 at edge k, so ones_q = 0 after edge k; prev_q still holds 9 until edge k+1.
  - wrap is true in the cycle after edge k.
  - tens updates at edge k+1.
  - tens → seg takes one further edge when sel = 1.
- sel period: 2·REFRESH_DIV cycles, 50 % duty.
  - seg changes in the same edge as sel; no blanking gap.
- Simultaneous events:
  - Wrap on a sel-toggle edge: tens and sel update together, and seg reflects the old tens for one cycle.
  - Illegal code and wrap are mutually exclusive by definition.

## Structure
- Package ssd_pkg holds:
  - the segment constants (SEG_0..SEG_9, SEG_DASH = 7'h40, SEG_BLANK = 7'h00);
  - the BCD_MAX = 4'd9 constant.
- Sub-module bcd_to_seg: purely combinational, 4-bit in / 7-bit out, using ssd_pkg constants. It is instantiated once, after the sel mux.
- Refresh counter width: $clog2(REFRESH_DIV).

## Test plan
Directed scenarios; simulate with REFRESH_DIV = 4.
- Reset: hold rst_n low mid-refresh → seg = 0x00, sel = 0, tens = 0, err = 0 immediately; after release, sel first toggles after exactly 4 cycles.
- Digit display: bcd_in = 7, observe a sel = 0 phase → seg = 0x07; with tens = 0 and BLANK_LZ = 1, the sel = 1 phase gives seg = 0x00.
- Wrap: bcd_in 9 then 0 (held) → tens goes 0→1 exactly 2 edges after the bcd_in change and only once; the sel = 1 phase then shows 0x06.
- Roll-over: drive 100 decade sequences 0..9 → tens returns to 0 with roll = 1 for exactly one cycle.
- Illegal code: bcd_in = 12 → the sel = 0 phase shows 0x40 and err = 1 from the next edge; then 9→12→0 → no tens increment and err stays 1.
- Non-wrap transitions: 3→0 and 0→0 held → tens unchanged.
